// File: rtl/alu_exec_pkg.sv
// Shared types and encodings for the ALU execute stage.
package alu_exec_pkg;

    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned SHAMT_W_DEF = 5;
    localparam int unsigned OP_W        = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_XOR  = 4'd3,
        OP_DIFF = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7
    } aluOp_e;

    localparam logic [1:0] SEL_DIFF   = 2'b00;
    localparam logic [1:0] SEL_ADDSUB = 2'b01;
    localparam logic [1:0] SEL_XOR    = 2'b10;
    localparam logic [1:0] SEL_AND    = 2'b11;

    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SRL = 2'b01;
    localparam logic [1:0] SH_SRA = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } execState_e;

endpackage

// File: rtl/alu_exec_stage_decode.sv
// Combinational opcode-to-ALU-control mapping; illegal opcodes yield all-zero controls.
module alu_op_decode
    import alu_exec_pkg::*;
(
    input  logic [OP_W-1:0] op,
    output logic            addrSrcBSel,
    output logic [1:0]      primaryOutSel,
    output logic [1:0]      shiftType,
    output logic            shiftEnbl,
    output logic            carryOp,
    output logic            illegal
);

    always_comb begin
        addrSrcBSel   = 1'b0;
        primaryOutSel = SEL_DIFF;
        shiftType     = SH_SLL;
        shiftEnbl     = 1'b0;
        carryOp       = 1'b0;
        illegal       = 1'b0;
        case (op)
            OP_ADD: begin
                primaryOutSel = SEL_ADDSUB;
                carryOp       = 1'b1;
            end
            OP_SUB: begin
                primaryOutSel = SEL_ADDSUB;
                addrSrcBSel   = 1'b1;
                carryOp       = 1'b1;
            end
            OP_AND:  primaryOutSel = SEL_AND;
            OP_XOR:  primaryOutSel = SEL_XOR;
            OP_DIFF: primaryOutSel = SEL_DIFF;
            OP_SLL: begin
                shiftEnbl = 1'b1;
                shiftType = SH_SLL;
            end
            OP_SRL: begin
                shiftEnbl = 1'b1;
                shiftType = SH_SRL;
            end
            OP_SRA: begin
                shiftEnbl = 1'b1;
                shiftType = SH_SRA;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Issue/execute/hold stage driving an external ALU, one op per two cycles sustained.
// Optional architectural flag register enabled by defining ALU_EXEC_FLAGS_EN.
module alu_exec_stage
    import alu_exec_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned SHAMT_W = SHAMT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    in_op,
    input  logic [DATA_W-1:0]  in_a,
    input  logic [DATA_W-1:0]  in_b,
    input  logic [SHAMT_W-1:0] in_shamt,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic               alu_addr_src_b_sel,
    output logic [1:0]         alu_primary_out_sel,
    output logic [1:0]         alu_shift_type,
    output logic [SHAMT_W-1:0] alu_shift_amnt,
    output logic               alu_shift_enbl,
    input  logic [DATA_W-1:0]  alu_out,
    input  logic               alu_c_out,
    input  logic               alu_msb,
    input  logic               alu_zero,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_result,
    output logic               out_err,
    output logic               flag_z,
    output logic               flag_c,
    output logic               flag_n
);

    execState_e state, nextState;
    logic       accept;
    logic       opIllegal;

    logic       decAddrSrcBSel;
    logic [1:0] decPrimaryOutSel;
    logic [1:0] decShiftType;
    logic       decShiftEnbl;
    logic       decCarryOp;
    logic       decIllegal;

    alu_op_decode uDecode (
        .op            (in_op),
        .addrSrcBSel   (decAddrSrcBSel),
        .primaryOutSel (decPrimaryOutSel),
        .shiftType     (decShiftType),
        .shiftEnbl     (decShiftEnbl),
        .carryOp       (decCarryOp),
        .illegal       (decIllegal)
    );

    assign accept    = in_valid & in_ready;
    assign out_valid = (state == ST_HOLD);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= nextState;
    end

    // in_ready is forced low during reset so nothing is accepted on the reset edge.
    always_comb begin
        nextState = state;
        in_ready  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                in_ready = ~rst;
                if (accept) nextState = ST_EXEC;
            end
            ST_EXEC: nextState = ST_HOLD;
            ST_HOLD: begin
                in_ready = ~rst & out_ready;
                if (accept)         nextState = ST_EXEC;
                else if (out_ready) nextState = ST_IDLE;
            end
            default: nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a               <= '0;
            alu_b               <= '0;
            alu_addr_src_b_sel  <= 1'b0;
            alu_primary_out_sel <= '0;
            alu_shift_type      <= '0;
            alu_shift_amnt      <= '0;
            alu_shift_enbl      <= 1'b0;
            opIllegal           <= 1'b0;
            out_result          <= '0;
            out_err             <= 1'b0;
        end else begin
            if (accept) begin
                alu_a               <= in_a;
                alu_b               <= in_b;
                alu_addr_src_b_sel  <= decAddrSrcBSel;
                alu_primary_out_sel <= decPrimaryOutSel;
                alu_shift_type      <= decShiftType;
                alu_shift_amnt      <= decShiftEnbl ? in_shamt : '0;
                alu_shift_enbl      <= decShiftEnbl;
                opIllegal           <= decIllegal;
            end
            if (state == ST_EXEC) begin
                out_result <= opIllegal ? '0 : alu_out;
                out_err    <= opIllegal;
            end
        end
    end

`ifdef ALU_EXEC_FLAGS_EN
    logic carryOpQ;

    always_ff @(posedge clk) begin
        if (rst) begin
            carryOpQ <= 1'b0;
            flag_z   <= 1'b0;
            flag_c   <= 1'b0;
            flag_n   <= 1'b0;
        end else begin
            if (accept) carryOpQ <= decCarryOp;
            if (state == ST_EXEC && !opIllegal) begin
                flag_z <= alu_zero;
                flag_n <= alu_msb;
                flag_c <= carryOpQ & alu_c_out;
            end
        end
    end
`else
    logic unusedFlagInputs;
    assign unusedFlagInputs = ^{alu_zero, alu_msb, alu_c_out, decCarryOp};
    assign flag_z = 1'b0;
    assign flag_c = 1'b0;
    assign flag_n = 1'b0;
`endif

endmodule
